// File: rtl/note_tone_generator.sv
// note_tone_generator: decodes a one-hot note word plus octave into a registered square-wave speaker drive.
// Latency: a new valid word is captured on edge 1 and loaded on edge 2; the first low half-period starts there.
// Flow: no backpressure; data_valid or en low silences the output and returns to IDLE on the next edge.
// Optional feature macro: TONE_GAP_EN inserts a GAP_CYCLES articulation silence between consecutive notes.
module note_tone_generator #(
  parameter int DATA_WIDTH = 10,
  parameter int DIV_WIDTH  = 20,
  parameter int GAP_CYCLES = 2000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  speaker,
  output logic                  note_active,
  output logic [DIV_WIDTH-1:0]  half_period
);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, REST, GAP} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] held, held_nxt;
  logic [DIV_WIDTH-1:0]  phase, phase_nxt;
  logic [DIV_WIDTH-1:0]  hp_nxt;
  logic                  speaker_nxt;
  logic                  active_nxt;
  logic                  changed;

`ifdef TONE_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
`else
  logic [31:0] unused_gap_cycles;
  assign unused_gap_cycles = GAP_CYCLES;
`endif

  // Middle-octave half period of the lowest set note bit, then shifted by octave; zero means rest.
  function automatic logic [DIV_WIDTH-1:0] note_div(input logic [8:0] w);
    logic [DIV_WIDTH-1:0] base;
    base = '0;
    if      (w[2]) base = DIV_WIDTH'(191113);
    else if (w[3]) base = DIV_WIDTH'(170262);
    else if (w[4]) base = DIV_WIDTH'(151686);
    else if (w[5]) base = DIV_WIDTH'(143173);
    else if (w[6]) base = DIV_WIDTH'(127551);
    else if (w[7]) base = DIV_WIDTH'(113636);
    else if (w[8]) base = DIV_WIDTH'(101238);
    case (w[1:0])
      2'b10:   note_div = base >> 1;
      2'b01:   note_div = base << 1;
      default: note_div = base;
    endcase
  endfunction

  // Next-state and next-output logic; stop conditions override every state.
  always_comb begin
    state_nxt   = state;
    held_nxt    = held;
    phase_nxt   = phase;
    speaker_nxt = speaker;
    active_nxt  = note_active;
    hp_nxt      = half_period;
`ifdef TONE_GAP_EN
    gap_cnt_nxt = gap_cnt;
`endif
    changed     = data_valid && (data_in != held);

    if (!en || !data_valid) begin
      state_nxt   = IDLE;
      held_nxt    = '0;
      phase_nxt   = '0;
      speaker_nxt = 1'b0;
      active_nxt  = 1'b0;
      hp_nxt      = '0;
    end else begin
      case (state)
        IDLE: begin
          held_nxt    = data_in;
          state_nxt   = LOAD;
          speaker_nxt = 1'b0;
          active_nxt  = 1'b0;
          hp_nxt      = '0;
        end
        LOAD: begin
          phase_nxt   = '0;
          speaker_nxt = 1'b0;
          hp_nxt      = note_div(held[8:0]);
          if (hp_nxt == '0) begin
            state_nxt  = REST;
            active_nxt = 1'b0;
          end else begin
            state_nxt  = PLAY;
            active_nxt = 1'b1;
          end
        end
        PLAY: begin
          if (changed) begin
            held_nxt    = data_in;
            speaker_nxt = 1'b0;
            active_nxt  = 1'b0;
`ifdef TONE_GAP_EN
            state_nxt   = GAP;
            gap_cnt_nxt = '0;
            hp_nxt      = '0;
`else
            state_nxt   = LOAD;
`endif
          end else if (phase == half_period - DIV_WIDTH'(1)) begin
            phase_nxt   = '0;
            speaker_nxt = ~speaker;
          end else begin
            phase_nxt   = phase + DIV_WIDTH'(1);
          end
        end
        REST: begin
          speaker_nxt = 1'b0;
          active_nxt  = 1'b0;
          if (changed) begin
            held_nxt  = data_in;
            state_nxt = LOAD;
          end
        end
`ifdef TONE_GAP_EN
        GAP: begin
          speaker_nxt = 1'b0;
          active_nxt  = 1'b0;
          hp_nxt      = '0;
          if (changed) begin
            held_nxt    = data_in;
            gap_cnt_nxt = '0;
          end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state_nxt   = LOAD;
          end else begin
            gap_cnt_nxt = gap_cnt + GAP_W'(1);
          end
        end
`endif
        default: begin
          state_nxt   = IDLE;
          held_nxt    = '0;
          phase_nxt   = '0;
          speaker_nxt = 1'b0;
          active_nxt  = 1'b0;
          hp_nxt      = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      held        <= '0;
      phase       <= '0;
      speaker     <= 1'b0;
      note_active <= 1'b0;
      half_period <= '0;
`ifdef TONE_GAP_EN
      gap_cnt     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      held        <= held_nxt;
      phase       <= phase_nxt;
      speaker     <= speaker_nxt;
      note_active <= active_nxt;
      half_period <= hp_nxt;
`ifdef TONE_GAP_EN
      gap_cnt     <= gap_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_note_tone_generator.sv
// Bench for note_tone_generator: random and directed note words against a timeline model.
module tb_note_tone_generator;
  localparam int GAP = 10;

  logic        clk = 1'b0;
  logic        rst, en, data_valid;
  logic [9:0]  data_in;
  logic        speaker, note_active;
  logic [19:0] half_period;

  note_tone_generator #(.DATA_WIDTH(10), .DIV_WIDTH(20), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .data_valid(data_valid),
    .speaker(speaker), .note_active(note_active), .half_period(half_period)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  // Model: which word is held, whether the next edge loads it, and when the current tone started.
  logic [9:0] m_word;
  bit         m_engaged, m_pending, m_playing;
  int         m_hp;
  longint     m_start;
  int         m_gap_left;
  int         mid_period [7] = '{191113, 170262, 151686, 143173, 127551, 113636, 101238};

  function automatic int period_of(input logic [9:0] w);
    int p;
    p = 0;
    for (int i = 6; i >= 0; i--) if (w[2+i]) p = mid_period[i];
    if (w[1:0] == 2'b10) p = p / 2;
    else if (w[1:0] == 2'b01) p = p * 2;
    return p;
  endfunction

  task automatic model_clear();
    m_word = '0; m_engaged = 0; m_pending = 0; m_playing = 0;
    m_hp = 0; m_start = 0; m_gap_left = 0;
  endtask

  task automatic model_edge();
    if (rst || !en || !data_valid) begin
      model_clear();
    end else if (m_pending) begin
      m_pending = 0;
      m_hp      = period_of(m_word);
      m_playing = (m_hp != 0);
      m_start   = cyc;
    end else if (m_gap_left > 0) begin
      if (data_in != m_word) begin
        m_word = data_in; m_gap_left = GAP;
      end else begin
        m_gap_left--;
        if (m_gap_left == 0) m_pending = 1;
      end
    end else if (!m_engaged) begin
      m_engaged = 1; m_word = data_in; m_pending = 1;
    end else if (data_in != m_word) begin
      m_word = data_in;
`ifdef TONE_GAP_EN
      if (m_playing) begin m_gap_left = GAP; m_hp = 0; end
      else m_pending = 1;
`else
      m_pending = 1;
`endif
      m_playing = 0;
    end
  endtask

  task automatic check(input string tag);
    logic [21:0] obs, exp;
    logic        spk;
    spk = 1'b0;
    if (m_playing && m_hp > 0) spk = (((cyc - m_start) / m_hp) % 2) == 1;
    exp = {spk, m_playing, 20'(m_hp)};
    obs = {speaker, note_active, half_period};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: spk/act/hp observed %0b/%0b/%0d expected %0b/%0b/%0d",
             tag, cyc, obs[21], obs[20], obs[19:0], exp[21], exp[20], exp[19:0]);
    end
  endtask

  task automatic expect_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick(input bit chk, input string tag);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    if (chk) check(tag);
  endtask

  initial begin
    int     r, hold;
    longint k;
    model_clear();
    rst = 1'b1; en = 1'b0; data_valid = 1'b0; data_in = '0;
    for (int i = 0; i < 3; i++) tick(1, "reset");

    // Enabled but no valid word: silent throughout.
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 100; i++) tick(1, "idle_no_valid");

    // Random words, repeats, rests, drops of valid/en and occasional reset.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 11);
      rst = 1'b0; en = 1'b1; data_valid = 1'b1;
      case (r)
        0: data_valid = 1'b0;
        1: en = 1'b0;
        2: ; // same word again
        3: data_in = 10'($urandom_range(0, 3));
        4: rst = 1'b1;
        default: data_in = 10'($urandom);
      endcase
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) tick(1, "random");
    end
    rst = 1'b0; en = 1'b1;

    // la, middle octave.
    data_valid = 1'b0; tick(1, "drop");
    data_valid = 1'b1; data_in = 10'b0010000000;
    tick(1, "la_capture");
    tick(1, "la_load");
    expect_val("la_hp", int'(half_period), 113636);
    expect_val("la_active", int'(note_active), 1);
    for (int i = 0; i < 20; i++) tick(1, "la_play");

    // do, high octave, mid-note.
    data_in = 10'b0000000110;
    tick(1, "do_hi_load");
    expect_val("do_hi_load_spk", int'(speaker), 0);
    tick(1, "do_hi_play");
    expect_val("do_hi_hp", int'(half_period), 95556);
    for (int i = 0; i < 10; i++) tick(1, "do_hi_play");

    // Rest in low octave, then si low.
    data_in = 10'b0000000001;
    tick(1, "rest_load"); tick(1, "rest");
    expect_val("rest_hp", int'(half_period), 0);
    expect_val("rest_active", int'(note_active), 0);
    data_in = 10'b0100000001;
    tick(1, "si_lo_load"); tick(1, "si_lo");
    expect_val("si_lo_hp", int'(half_period), 202476);

    // so -> fa change: immediate LOAD, or a gap when the feature is built in.
    data_in = 10'b0001000000;
    for (int i = 0; i < 5; i++) tick(1, "so");
    data_in = 10'b0000100000;
    for (int i = 0; i < GAP + 5; i++) tick(1, "so_to_fa");
    expect_val("fa_hp", int'(half_period), 143173);
    expect_val("fa_active", int'(note_active), 1);

    // si high: watch the first rising edge, then reset while speaker is high.
    data_valid = 1'b0; tick(1, "drop");
    data_valid = 1'b1; data_in = 10'b0100000010;
    tick(1, "si_hi_capture"); tick(1, "si_hi_load");
    expect_val("si_hi_hp", int'(half_period), 50619);
    k = cyc - m_start;
    while (k < 50619 + 3) begin
      k = cyc + 1 - m_start;
      tick((k % 64 == 0) || (k >= 50619 - 2), "si_hi_run");
    end
    expect_val("si_hi_spk_high", int'(speaker), 1);
    rst = 1'b1;
    tick(1, "rst_mid_note");
    expect_val("rst_spk", int'(speaker), 0);
    expect_val("rst_hp", int'(half_period), 0);
    rst = 1'b0;
    tick(1, "post_rst_capture"); tick(1, "post_rst_load");
    for (int i = 0; i < 5; i++) tick(1, "post_rst_play");

    // Drop valid mid-note, then the same word re-triggers a fresh load.
    data_valid = 1'b0;
    tick(1, "drop_mid_note");
    expect_val("drop_active", int'(note_active), 0);
    data_valid = 1'b1;
    tick(1, "retrigger_capture");
    tick(1, "retrigger_load");
    expect_val("retrigger_active", int'(note_active), 1);
    expect_val("retrigger_hp", int'(half_period), 50619);
    for (int i = 0; i < 5; i++) tick(1, "retrigger_play");

    // en low silences immediately.
    en = 1'b0;
    tick(1, "en_low");
    expect_val("en_low_active", int'(note_active), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
